// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction-fetch stage (PC sequencing, imem req/ready handshake, IF register).
// Build option FETCH_STATS_EN adds fetch_count, the number of words delivered into the IF register.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam logic [31:0] PC_START = PC_RESET & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, FETCH, PEND, DRAIN} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] tgt, tgt_n;
  logic [31:0] pend_word, pend_pc;
  logic [31:0] target;
  logic [31:0] load_word, load_pc;
  logic        pend_wr, load, flush, consume, out_free;

  assign target   = redirect_pc & 32'hFFFF_FFFC;
  assign out_free = !instr_valid || !stall;
  assign consume  = instr_valid && !stall;
  assign flush    = redirect && (state != IDLE);

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign pc_plus4  = pc_out + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    tgt_n     = tgt;
    pend_wr   = 1'b0;
    load      = 1'b0;
    load_word = '0;
    load_pc   = '0;
    imem_req  = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          if (imem_ready) begin
            pc_n = target;
          end else begin
            tgt_n   = target;
            state_n = DRAIN;
          end
        end else if (imem_ready) begin
          pc_n = pc + 32'd4;
          if (out_free) begin
            load      = 1'b1;
            load_word = imem_rdata;
            load_pc   = pc;
          end else begin
            pend_wr = 1'b1;
            state_n = PEND;
          end
        end
      end
      PEND: begin
        if (redirect) begin
          pc_n    = target;
          state_n = FETCH;
        end else if (!stall) begin
          load      = 1'b1;
          load_word = pend_word;
          load_pc   = pend_pc;
          state_n   = FETCH;
        end
      end
      DRAIN: begin
        // The request must stay up until the stale response arrives; a redirect
        // landing on that same cycle is taken directly instead of re-draining.
        imem_req = 1'b1;
        if (imem_ready) begin
          pc_n    = redirect ? target : tgt;
          state_n = FETCH;
        end else if (redirect) begin
          tgt_n = target;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= PC_START;
      tgt         <= '0;
      pend_word   <= '0;
      pend_pc     <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      pc_out      <= '0;
    end else begin
      pc  <= pc_n;
      tgt <= tgt_n;
      if (pend_wr) begin
        pend_word <= imem_rdata;
        pend_pc   <= pc;
      end
      if (load) begin
        instr       <= load_word;
        pc_out      <= load_pc;
        instr_valid <= 1'b1;
      end else if (flush || consume) begin
        instr_valid <= 1'b0;
        instr       <= '0;
      end
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     fetch_count <= '0;
    else if (load) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table for redirect/stall corners, scoreboard for streams.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] TAG = 32'h8C00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req, imem_ready, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, pc_out, pc_plus4;
  logic [5:0]  opcode;

  logic        stall_w = 1'b0;
  logic        redirect_w = 1'b0;
  logic [31:0] redirect_pc_w = '0;
  logic        req_w, ready_w, valid_w;
  logic [31:0] addr_w, rdata_w, instr_w, pc_out_w, pc_plus4_w;
  logic [5:0]  opcode_w;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, fetch_count_w;
`endif

  int checks = 0;
  int failures = 0;
  int unsigned mem_lat = 0;
  int unsigned w = 0;
  logic        sb_on = 1'b0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .pc_out(pc_out), .pc_plus4(pc_plus4)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count)
`endif
  );

  fetch_unit #(.PC_RESET(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .stall(stall_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
    .imem_req(req_w), .imem_addr(addr_w), .imem_ready(ready_w), .imem_rdata(rdata_w),
    .instr_valid(valid_w), .instr(instr_w), .opcode(opcode_w), .pc_out(pc_out_w), .pc_plus4(pc_plus4_w)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count_w)
`endif
  );

  // Memory model: data is the address xor TAG; ready after mem_lat wait cycles.
  always_comb imem_ready = imem_req && (w >= mem_lat);
  always_comb imem_rdata = imem_addr ^ TAG;
  always_comb ready_w    = req_w;
  always_comb rdata_w    = addr_w ^ TAG;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        w <= 0;
    else if (imem_req && imem_ready)  w <= 0;
    else if (imem_req)                w <= w + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every word taken by decode must be the next expected address, in order.
  always @(negedge clk) begin
    if (sb_on && !reset && instr_valid && !stall && sb_q.size() > 0) begin
      logic [31:0] e;
      e = sb_q.pop_front();
      chk("sb instr", instr, e ^ TAG);
      chk("sb pc_out", pc_out, e);
      chk("sb pc_plus4", pc_plus4, e + 32'd4);
    end
  end

  task automatic do_reset(input int unsigned lat);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    sb_on = 1'b0; sb_q.delete(); mem_lat = lat;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_sb_empty(input string name);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, sb_q.size(), 0);
    sb_on = 1'b0;
  endtask

  typedef struct packed {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [31:0] ei;
    logic        saw_req0;
    int          n;

    vt[0]  = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0040_0000, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_0000, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_0004, 1'b1, 32'h0040_0000};
    vt[3]  = '{1'b1, 1'b1, 32'h0040_0103,  1'b1, 32'h0040_0008, 1'b1, 32'h0040_0004};
    vt[4]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_0100, 1'b0, 32'h0};
    vt[5]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_0104, 1'b1, 32'h0040_0100};
    vt[6]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h0040_0108, 1'b1, 32'h0040_0104};
    vt[7]  = '{1'b1, 1'b1, 32'h0040_0200,  1'b0, 32'h0040_010C, 1'b1, 32'h0040_0104};
    vt[8]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h0040_0200, 1'b0, 32'h0};
    vt[9]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h0040_0204, 1'b1, 32'h0040_0200};
    vt[10] = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0040_0208, 1'b1, 32'h0040_0200};
    vt[11] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_0208, 1'b1, 32'h0040_0204};
    vt[12] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h0040_020C, 1'b1, 32'h0040_0208};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst imem_addr", imem_addr, 32'h0040_0000);
    chk("rst instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst instr", instr, 32'h0);
    chk("rst opcode", {26'b0, opcode}, 32'h0);
    chk("rst pc_out", pc_out, 32'h0);
    chk("rst pc_plus4", pc_plus4, 32'h4);
    chk("rst wrap imem_addr", addr_w, 32'hFFFF_FFF8);

    // Cycle table: zero-wait memory, redirect with ready under stall, pend/redirect in PEND
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      stall = vt[i].st; redirect = vt[i].rd; redirect_pc = vt[i].rpc;
      @(negedge clk);
      ei = vt[i].vld ? (vt[i].pc ^ TAG) : 32'h0;
      chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vt[i].req});
      chk($sformatf("v%0d imem_addr", i), imem_addr, vt[i].addr);
      chk($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vt[i].vld});
      chk($sformatf("v%0d instr", i), instr, ei);
      chk($sformatf("v%0d opcode", i), {26'b0, opcode}, {26'b0, ei[31:26]});
      if (vt[i].vld) begin
        chk($sformatf("v%0d pc_out", i), pc_out, vt[i].pc);
        chk($sformatf("v%0d pc_plus4", i), pc_plus4, vt[i].pc + 32'd4);
      end
      @(posedge clk); #1;
    end

    // Zero-wait stream through the scoreboard
    do_reset(0);
    for (int k = 0; k < 12; k++) sb_q.push_back(32'h0040_0000 + 32'(k * 4));
    sb_on = 1'b1;
    wait_sb_empty("stream0 drained");

    // Two-cycle memory, stall held 3 cycles while 0x00400004 is in the IF register
    do_reset(1);
    for (int k = 0; k < 6; k++) sb_q.push_back(32'h0040_0000 + 32'(k * 4));
    sb_on = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(instr_valid && pc_out == 32'h0040_0000) && n < 40);
    chk("stall trigger found", {31'b0, (n < 40)}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    stall = 1'b1;
    saw_req0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall hold pc_out", pc_out, 32'h0040_0004);
      chk("stall hold valid", {31'b0, instr_valid}, 32'h1);
      if (!imem_req) saw_req0 = 1'b1;
      @(posedge clk); #1;
    end
    stall = 1'b0;
    chk("pend imem_req low", {31'b0, saw_req0}, 32'h1);
    @(negedge clk);
    chk("pend still old", pc_out, 32'h0040_0004);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pend released pc_out", pc_out, 32'h0040_0008);
    chk("pend released instr", instr, 32'h0040_0008 ^ TAG);
    wait_sb_empty("stall stream drained");

    // Redirect during a 3-cycle fetch of 0x00400010 -> DRAIN
    do_reset(2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(imem_req && imem_addr == 32'h0040_0010 && w == 0) && n < 60);
    chk("drain trigger found", {31'b0, (n < 60)}, 32'h1);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h0040_0100;
    @(posedge clk); #1;
    redirect = 1'b0;
    sb_q.push_back(32'h0040_0100);
    sb_q.push_back(32'h0040_0104);
    sb_on = 1'b1;
    @(negedge clk);
    chk("drain imem_req", {31'b0, imem_req}, 32'h1);
    chk("drain addr held", imem_addr, 32'h0040_0010);
    chk("drain instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("drain instr nop", instr, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain next addr", imem_addr, 32'h0040_0100);
    chk("drain still invalid", {31'b0, instr_valid}, 32'h0);
    wait_sb_empty("drain stream drained");

    // Address wrap with PC_RESET = 0xFFFFFFF8
    do_reset(0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap addr0", addr_w, 32'hFFFF_FFF8);
    chk("wrap req", {31'b0, req_w}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap addr1", addr_w, 32'hFFFF_FFFC);
    chk("wrap pc_out0", pc_out_w, 32'hFFFF_FFF8);
    chk("wrap opcode0", {26'b0, opcode_w}, {26'b0, 6'h1C});
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap addr2", addr_w, 32'h0000_0000);
    chk("wrap pc_out1", pc_out_w, 32'hFFFF_FFFC);
    chk("wrap pc_plus4", pc_plus4_w, 32'h0000_0000);
    chk("wrap valid", {31'b0, valid_w}, 32'h1);

    // Asynchronous reset mid-cycle while fetching
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async imem_req", {31'b0, imem_req}, 32'h0);
    chk("async imem_addr", imem_addr, 32'h0040_0000);
    chk("async instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("async instr", instr, 32'h0);
    chk("async pc_out", pc_out, 32'h0);
    chk("async pc_plus4", pc_plus4, 32'h4);
    chk("async wrap addr", addr_w, 32'hFFFF_FFF8);

`ifdef FETCH_STATS_EN
    do_reset(0);
    repeat (11) begin
      @(posedge clk); #1;
    end
    redirect = 1'b1; redirect_pc = 32'h0040_0100;
    repeat (2) begin
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    @(negedge clk);
    chk("fetch_count", fetch_count, 32'd10);
    #2;
    reset = 1'b1;
    #1;
    chk("fetch_count reset", fetch_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS datapath. Sequences the program counter, issues requests to instruction memory over a req/ready handshake, and holds the fetched word in an IF output register whose opcode field drives the control unit directly. Supports back-pressure from the decode side, a one-entry pending buffer, and branch/jump redirect with discard of an in-flight fetch.

## Interface
- PC_RESET, 32'h0040_0000, fetch address after reset; bits [1:0] must be 00
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  decode cannot accept; hold current output
- redirect  in  1  taken branch/jump; flush and refetch from redirect_pc
- redirect_pc  in  32  target address; bits [1:0] ignored, forced to 00
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch word address
- imem_ready  in  1  imem_rdata valid this cycle; sampled only while imem_req=1
- imem_rdata  in  32  fetched instruction
- instr_valid  out  1  instr/pc_out hold a live instruction
- instr  out  32  IF register instruction word
- opcode  out  6  instr[31:26], to control unit OP input
- pc_out  out  32  address of instr
- pc_plus4  out  32  pc_out + 4, for branch target/link

## Operation
- Registers: pc (next fetch address), tgt (saved redirect target), pend (32-bit word + its pc), output register (instr, pc_out, instr_valid).
- out_free = !instr_valid || !stall.
- States:
  - IDLE: entered on reset; imem_req=0; unconditionally → FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready: if out_free, load output register (instr=imem_rdata, pc_out=pc, instr_valid=1), pc += 4, stay FETCH; else store word in pend, pc += 4, → PEND. No ready: hold, imem_addr stable. If !out_free and no ready, the request stays up (memory contract: req never drops before ready).
  - PEND: imem_req=0; output held. When stall=0: output register ← pend, → FETCH.
  - DRAIN: imem_req=1, imem_addr=pc (old address, held); on imem_ready discard data, pc ← tgt, → FETCH.
- Output consumption: when instr_valid && !stall and no new word loads, instr_valid ← 0 and instr ← 0 (NOP).
- redirect (highest priority, any state except IDLE): next cycle instr_valid=0, instr=0, pend discarded.
  - FETCH with imem_ready same cycle: response discarded, pc ← redirect_pc, stay FETCH.
  - FETCH without imem_ready: tgt ← redirect_pc, → DRAIN.
  - PEND: pc ← redirect_pc, → FETCH.
  - DRAIN: tgt ← redirect_pc (latest wins), stay DRAIN.
- redirect overrides stall.
- Arithmetic: pc and pc_plus4 modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values: imem_req=0, imem_addr=PC_RESET, instr_valid=0, instr=0, opcode=0, pc_out=0, pc_plus4=32'h4; state IDLE, pc=PC_RESET.
- First imem_req: second rising edge after reset deasserts (one IDLE cycle).
- Zero-wait memory (imem_ready combinational with req): one instruction per cycle; instr valid one cycle after ready.
- Redirect-to-new-request latency: 1 cycle (FETCH/PEND), plus remaining wait of outstanding fetch (DRAIN).
- opcode and pc_plus4 are combinational from the output register; no extra latency.
- Reset asserted mid-fetch: immediate return to IDLE; outstanding memory response ignored.

## Configuration
- FETCH_STATS_EN defined: adds output fetch_count [31:0], counts words loaded into the output register (including from pend, excluding discarded), reset 0, wraps modulo 2^32.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, zero-wait memory returning addr-as-data, stall=0 -> imem_addr 0x00400000, 0x00400004, ...; instr_valid from 3rd edge; pc_plus4 = pc_out+4 every cycle.
- 2-cycle memory latency, stall held 3 cycles at instr 0x00400004 -> 0x00400008 captured into pend, imem_req=0 in PEND, output unchanged until stall drops, then 0x00400008 appears, no word lost or duplicated.
- redirect to 0x00400100 while a 3-cycle fetch of 0x00400010 is outstanding -> DRAIN, instr_valid=0, old data discarded, next imem_addr 0x00400100.
- redirect and imem_ready same cycle, with stall=1 -> response dropped, output flushed to NOP (opcode 0), next request 0x00400100.
- PC_RESET=32'hFFFF_FFF8, two fetches -> addresses 0xFFFFFFF8, 0xFFFFFFFC, then 0x00000000; redirect_pc 0x00400103 -> fetch 0x00400100.
- With FETCH_STATS_EN, 10 delivered + 2 discarded words -> fetch_count=10; async reset mid-run -> all outputs at reset values same cycle.
